// File: rtl/masked_pkg.sv
// masked_pkg
//   Shared definitions for the masked datapath units.
//   DWIDTH_DEF / SHARES_DEF / DEPTH_DEF : default share width, share count and
//                                         buffer depth.
//   shr(i, dwidth)        : bit offset of share i inside a packed share vector.
//   ring_prev(i, shares)  : index of the ring predecessor of share i.
package masked_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int SHARES_DEF = 2;
  localparam int DEPTH_DEF  = 2;

  function automatic int shr(input int i, input int dwidth);
    return i * dwidth;
  endfunction

  function automatic int ring_prev(input int i, input int shares);
    return (i + shares - 1) % shares;
  endfunction

endpackage

// File: rtl/masked_refresh.sv
// masked_refresh
//   Combinational ring refresh of a Boolean-shared value:
//     out_i = in_i ^ R_i ^ R_((i-1) mod SHARES)
//   Every R_j appears in exactly two output shares, so the XOR of all shares
//   (the unmasked value) is unchanged. Each output share only combines one input
//   share with randomness; shares are never mixed with each other.
// Ports
//   InxDI      in   DWIDTH*SHARES  input shares, share i at [DWIDTH*i+:DWIDTH]
//   RandomxDI  in   DWIDTH*SHARES  fresh randomness R_i at [DWIDTH*i+:DWIDTH]
//   OutxDO     out  DWIDTH*SHARES  refreshed shares
module masked_refresh
  import masked_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int SHARES = SHARES_DEF
) (
  input  logic [DWIDTH*SHARES-1:0] InxDI,
  input  logic [DWIDTH*SHARES-1:0] RandomxDI,
  output logic [DWIDTH*SHARES-1:0] OutxDO
);

  for (genvar i = 0; i < SHARES; i++) begin : gen_share
    localparam int Lo     = shr(i, DWIDTH);
    localparam int PrevLo = shr(ring_prev(i, SHARES), DWIDTH);

    assign OutxDO[Lo+:DWIDTH] = InxDI[Lo+:DWIDTH] ^ RandomxDI[Lo+:DWIDTH]
                              ^ RandomxDI[PrevLo+:DWIDTH];
  end

endmodule

// File: rtl/masked_resp_buffer.sv
// masked_resp_buffer
//   Downstream stage of the masked adder/subtractor. Captures the one-cycle
//   result pulse, re-masks the shares with fresh randomness and holds them in a
//   small FIFO behind a valid/ready port. Upstream issue is throttled so that
//   every issued request has a guaranteed free slot when its result returns.
// Ports
//   ClkxCI         in   1               clock, rising edge
//   RstxBI         in   1               asynchronous active-high reset
//   IssuexSI       in   1               adder request accepted this cycle
//   IssueAllowxSO  out  1               upstream may issue a new request
//   InValidxSI     in   1               adder result pulse
//   InDataxDI      in   DWIDTH*SHARES   adder result shares
//   RandomxDI      in   DWIDTH*SHARES   refresh randomness
//   OutValidxSO    out  1               FIFO head valid
//   OutReadyxSI    in   1               consumer accepts head
//   OutDataxDO     out  DWIDTH*SHARES   head entry (refreshed shares)
//   CountxDO       out  $clog2(DEPTH)+1 occupancy
//   OverflowxSO    out  1               sticky: result arrived while full
module masked_resp_buffer
  import masked_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int SHARES = SHARES_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       ClkxCI,
  input  logic                       RstxBI,
  input  logic                       IssuexSI,
  output logic                       IssueAllowxSO,
  input  logic                       InValidxSI,
  input  logic [DWIDTH*SHARES-1:0]   InDataxDI,
  input  logic [DWIDTH*SHARES-1:0]   RandomxDI,
  output logic                       OutValidxSO,
  input  logic                       OutReadyxSI,
  output logic [DWIDTH*SHARES-1:0]   OutDataxDO,
  output logic [$clog2(DEPTH):0]     CountxDO,
  output logic                       OverflowxSO
);

  localparam int W  = DWIDTH * SHARES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  MemxDP [DEPTH];
  logic [PW-1:0] RdPtrxDP, WrPtrxDP;
  logic [CW-1:0] CountxDP;
  logic          InFlightxDP;
  logic          OverflowxDP;

  logic          PushxS, PopxS;
  logic [W-1:0]  RefreshedxD;
  logic [CW:0]   PendingxD;

  masked_refresh #(
    .DWIDTH (DWIDTH),
    .SHARES (SHARES)
  ) i_refresh (
    .InxDI     (InDataxDI),
    .RandomxDI (RandomxDI),
    .OutxDO    (RefreshedxD)
  );

  assign OutValidxSO = (CountxDP != '0);
  assign PopxS       = OutValidxSO & OutReadyxSI;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign PushxS      = InValidxSI & ((CountxDP < CW'(DEPTH)) | PopxS);

  // Entries already stored plus the result still owed by the adder must fit.
  assign PendingxD     = {1'b0, CountxDP} + {{CW{1'b0}}, InFlightxDP};
  assign IssueAllowxSO = (PendingxD < (CW+1)'(DEPTH));

  assign OutDataxDO  = MemxDP[RdPtrxDP];
  assign CountxDO    = CountxDP;
  assign OverflowxSO = OverflowxDP;

  // NOTE: the storage is reset as well so the head reads 0 after reset rather
  // than stale data; at this depth the extra reset wiring is negligible.
  always_ff @(posedge ClkxCI or posedge RstxBI) begin
    if (RstxBI) begin
      for (int i = 0; i < DEPTH; i++) MemxDP[i] <= '0;
    end else if (PushxS) begin
      MemxDP[WrPtrxDP] <= RefreshedxD;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge ClkxCI or posedge RstxBI) begin
    if (RstxBI) begin
      RdPtrxDP    <= '0;
      WrPtrxDP    <= '0;
      CountxDP    <= '0;
      InFlightxDP <= 1'b0;
      OverflowxDP <= 1'b0;
    end else begin
      if (PushxS) WrPtrxDP <= WrPtrxDP + PW'(1);
      if (PopxS)  RdPtrxDP <= RdPtrxDP + PW'(1);
      CountxDP <= CountxDP + CW'(PushxS) - CW'(PopxS);

      // A new issue in the result cycle wins: the adder is idle again.
      if (IssuexSI)        InFlightxDP <= 1'b1;
      else if (InValidxSI) InFlightxDP <= 1'b0;

      if (InValidxSI && !PushxS) OverflowxDP <= 1'b1;
    end
  end

endmodule

// File: tb/tb_masked_resp_buffer.sv
// tb_masked_resp_buffer
//   Bench for masked_resp_buffer: a 2-share instance driven from a vector table
//   and hand sequences, plus a 3-share instance under a random upstream/consumer.
//   Expected FIFO contents come from a reference refresh model and queues.
module tb_masked_resp_buffer;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-share instance
  logic        issue, allow, inV, outV, outRdy, ovf;
  logic [63:0] inData, rnd, outData;
  logic [1:0]  cnt;

  // 3-share instance
  logic        issue3, allow3, inV3, outV3, outRdy3, ovf3;
  logic [95:0] inData3, rnd3, outData3;
  logic [1:0]  cnt3;

  masked_resp_buffer #(.DWIDTH(32), .SHARES(2), .DEPTH(DEPTH)) dut (
    .ClkxCI(clk), .RstxBI(rst), .IssuexSI(issue), .IssueAllowxSO(allow),
    .InValidxSI(inV), .InDataxDI(inData), .RandomxDI(rnd),
    .OutValidxSO(outV), .OutReadyxSI(outRdy), .OutDataxDO(outData),
    .CountxDO(cnt), .OverflowxSO(ovf)
  );

  masked_resp_buffer #(.DWIDTH(32), .SHARES(3), .DEPTH(DEPTH)) dut3 (
    .ClkxCI(clk), .RstxBI(rst), .IssuexSI(issue3), .IssueAllowxSO(allow3),
    .InValidxSI(inV3), .InDataxDI(inData3), .RandomxDI(rnd3),
    .OutValidxSO(outV3), .OutReadyxSI(outRdy3), .OutDataxDO(outData3),
    .CountxDO(cnt3), .OverflowxSO(ovf3)
  );

  int nCmp = 0;
  int nErr = 0;

  logic [63:0] sb2[$];
  logic [95:0] sb3[$];

  typedef struct {
    string       name;
    logic        issue;
    logic        inV;
    logic        rdy;
    logic [63:0] data;
    logic [63:0] rnd;
    logic [1:0]  expCnt;
    logic        expVal;
    logic        expAllow;
    logic        expOvf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ring refresh for n 32-bit shares.
  function automatic logic [95:0] model_refresh(input logic [95:0] d, input logic [95:0] r, input int n);
    logic [95:0] res = '0;
    for (int i = 0; i < n; i++) begin
      int p = (i + n - 1) % n;
      res[32*i+:32] = d[32*i+:32] ^ r[32*i+:32] ^ r[32*p+:32];
    end
    return res;
  endfunction

  function automatic vec_t mk(input string name, input logic is, input logic iv, input logic rd,
                              input logic [63:0] d, input logic [63:0] r, input logic [1:0] c,
                              input logic v, input logic a, input logic o);
    vec_t t;
    t.name = name; t.issue = is; t.inV = iv; t.rdy = rd; t.data = d; t.rnd = r;
    t.expCnt = c; t.expVal = v; t.expAllow = a; t.expOvf = o;
    return t;
  endfunction

  // One clock: score pops/pushes for both instances from pre-edge inputs,
  // then advance to 1 time unit after the rising edge.
  task automatic cycle();
    int  n2 = sb2.size();
    int  n3 = sb3.size();
    bit  pop2 = outV && outRdy;
    bit  pop3 = outV3 && outRdy3;
    logic [95:0] e;
    if (pop2) begin
      check("pop2_has_expected", n2 != 0, 1'b1);
      if (n2 != 0) check("pop2_data", outData, sb2.pop_front());
    end
    if (inV && (n2 < DEPTH || pop2)) begin
      e = model_refresh({32'h0, inData}, {32'h0, rnd}, 2);
      sb2.push_back(e[63:0]);
    end
    if (pop3) begin
      check("pop3_has_expected", n3 != 0, 1'b1);
      if (n3 != 0) check("pop3_data", outData3, sb3.pop_front());
    end
    if (inV3 && (n3 < DEPTH || pop3)) sb3.push_back(model_refresh(inData3, rnd3, 3));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r0, r1, in0;
    bit          pending;
    int          dly;
    int          results;

    rst = 1'b1;
    issue = 0; inV = 0; outRdy = 0; inData = '0; rnd = '0;
    issue3 = 0; inV3 = 0; outRdy3 = 0; inData3 = '0; rnd3 = '0;

    // Reset state
    #3;
    check("rst_valid", outV, 1'b0);
    check("rst_count", cnt, 2'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_allow", allow, 1'b1);
    check("rst_data", outData, 64'h0);
    #9 rst = 1'b0;

    // Basic issue then result, known randomness
    issue = 1;
    cycle();
    check("t1_allow_inflight", allow, 1'b1);
    issue = 0;
    inV = 1;
    inData = {32'h0000_00FF, 32'h0000_0F0F};
    rnd    = {32'h1234_5678, 32'hCAFE_BABE};
    cycle();
    inV = 0;
    in0 = 32'h0000_0F0F; r0 = 32'hCAFE_BABE; r1 = 32'h1234_5678;
    check("t1_valid", outV, 1'b1);
    check("t1_unmasked", outData[63:32] ^ outData[31:0], 32'h0000_0FF0);
    check("t1_share0", outData[31:0], in0 ^ r0 ^ r1);
    check("t1_count", cnt, 2'd1);

    // Fill, overflow, full push+pop, drain, issue/result same cycle
    tbl.push_back(mk("issue2",  1, 0, 0, 64'h0, 64'h0, 2'd1, 1, 0, 0));
    tbl.push_back(mk("push2",   0, 1, 0, 64'hAAAA_0001_5555_0002, 64'h0F0F_1111_F0F0_2222, 2'd2, 1, 0, 0));
    tbl.push_back(mk("drop3",   0, 1, 0, 64'hDEAD_BEEF_0BAD_F00D, 64'h1357_9BDF_2468_ACE0, 2'd2, 1, 0, 1));
    tbl.push_back(mk("full_pp", 0, 1, 1, 64'h0000_1234_0000_4321, 64'h8888_7777_6666_5555, 2'd2, 1, 0, 1));
    tbl.push_back(mk("drain1",  0, 0, 1, 64'h0, 64'h0, 2'd1, 1, 1, 1));
    tbl.push_back(mk("drain2",  0, 0, 1, 64'h0, 64'h0, 2'd0, 0, 1, 1));
    tbl.push_back(mk("iss_res", 1, 1, 0, 64'h0102_0304_0506_0708, 64'hA5A5_5A5A_3C3C_C3C3, 2'd1, 1, 0, 1));
    tbl.push_back(mk("pop_e",   0, 0, 1, 64'h0, 64'h0, 2'd0, 0, 1, 1));
    tbl.push_back(mk("res_f",   0, 1, 0, 64'hFFFF_0000_0000_FFFF, 64'h0123_4567_89AB_CDEF, 2'd1, 1, 1, 1));
    tbl.push_back(mk("pop_f",   0, 0, 1, 64'h0, 64'h0, 2'd0, 0, 1, 1));

    foreach (tbl[k]) begin
      issue = tbl[k].issue; inV = tbl[k].inV; outRdy = tbl[k].rdy;
      inData = tbl[k].data; rnd = tbl[k].rnd;
      cycle();
      check({tbl[k].name, "_count"}, cnt,   tbl[k].expCnt);
      check({tbl[k].name, "_valid"}, outV,  tbl[k].expVal);
      check({tbl[k].name, "_allow"}, allow, tbl[k].expAllow);
      check({tbl[k].name, "_ovf"},   ovf,   tbl[k].expOvf);
    end
    issue = 0; inV = 0; outRdy = 0;

    // Overflow is sticky
    for (int k = 0; k < 10; k++) cycle();
    check("ovf_sticky", ovf, 1'b1);

    // Eight pushes through the two slots, wrapping pointers
    for (int k = 0; k < 8; k++) begin
      inV = 1; inData = {$urandom, $urandom}; rnd = {$urandom, $urandom};
      outRdy = (k >= 2);
      cycle();
      check("wrap_count", cnt, (k == 0) ? 2'd1 : 2'd2);
    end
    inV = 0; outRdy = 1;
    cycle();
    cycle();
    check("wrap_drained", cnt, 2'd0);
    check("wrap_sb_empty", sb2.size(), 0);
    outRdy = 0;

    // Asynchronous reset between edges with Count=2, InFlight=1
    inV = 1; inData = 64'h1111_2222_3333_4444; rnd = 64'h5;
    cycle();
    inData = 64'h5555_6666_7777_8888;
    cycle();
    inV = 0; issue = 1;
    cycle();
    issue = 0;
    check("pre_rst_count", cnt, 2'd2);
    check("pre_rst_allow", allow, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", outV, 1'b0);
    check("async_rst_count", cnt, 2'd0);
    check("async_rst_allow", allow, 1'b1);
    check("async_rst_ovf", ovf, 1'b0);
    sb2.delete();
    sb3.delete();
    #2 rst = 1'b0;
    cycle();
    check("post_rst_count", cnt, 2'd0);

    // Random regression on the 3-share instance
    pending = 0; dly = 0; results = 0;
    for (int c = 0; c < 3000 || pending; c++) begin
      if (c > 5000) begin
        check("random_finish_bound", 1'b0, 1'b1);
        break;
      end
      inV3 = pending && (dly == 0);
      if (inV3) begin
        inData3 = {$urandom, $urandom, $urandom};
        rnd3    = {$urandom, $urandom, $urandom};
        pending = 0;
        results++;
      end
      issue3 = (c < 3000) && allow3 && !pending && ($urandom_range(0, 3) != 0);
      if (issue3) begin
        pending = 1;
        dly = $urandom_range(0, 2);
      end else if (pending && dly > 0) begin
        dly--;
      end
      outRdy3 = ((c / 64) % 3 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cycle();
      check("rand_count", cnt3, sb3.size());
    end
    issue3 = 0; inV3 = 0; outRdy3 = 1;
    for (int k = 0; k < 10 && outV3; k++) cycle();
    outRdy3 = 0;
    check("rand_drained", outV3, 1'b0);
    check("rand_sb_empty", sb3.size(), 0);
    check("rand_no_ovf", ovf3, 1'b0);
    check("rand_enough_results", results > 500, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
